// File: rtl/clk_tick_pkg.sv
// -----------------------------------------------------------------------------
// clk_tick_pkg
//   Shared definitions for the clock/reset sequencer clk_tick_gen and its
//   per-channel divider tick_div.
//
//   Contents:
//     state_t      - lock/reset sequencer states (2-bit encoding)
//     MODE_PULSE   - channel emits a one-cycle pulse per divider period
//     MODE_SQUARE  - channel emits a square wave, high for floor(DIV/2) cycles
//     clog2()      - ceil(log2(value)); 0 for value <= 1
// -----------------------------------------------------------------------------
package clk_tick_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,   // waiting for the synchronised PLL lock
        STABLE    = 2'd1,   // lock seen; checking it stays up for LOCK_CYC cycles
        HOLD      = 2'd2,   // lock qualified; holding sys_rst for RST_HOLD cycles
        RUN       = 2'd3    // system out of reset, channels running
    } state_t;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : clk_tick_pkg

// File: rtl/tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
//   One clock-enable channel: a DIV_W-bit counter running 0 .. div-1 and a
//   registered tick output that is either a one-cycle pulse at the wrap
//   (MODE_PULSE) or a square wave high while the counter is below div/2
//   (MODE_SQUARE).
//
//   Ports:
//     clk     in   system clock
//     rst     in   asynchronous active-high reset
//     en      in   channel enabled (the sequencer is, or is about to be, in RUN);
//                  when low the counter and tick are forced to 0 on this edge
//     resync  in   realign: counter to 0, no tick this edge
//     div     in   DIV_W-bit divisor; values 0 and 1 make tick constant 1
//     mode    in   MODE_PULSE or MODE_SQUARE
//     tick    out  registered channel output
// -----------------------------------------------------------------------------
module tick_div
    import clk_tick_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             en_q;     // en delayed one cycle: low on the RUN-entry edge
    logic             degenerate;
    logic             wrap;
    logic [DIV_W-1:0] half;

    assign degenerate = (div <= DIV_W'(1));
    // >= rather than == so a divisor lowered at runtime cannot strand the
    // counter above the new wrap point.
    assign wrap       = (cnt >= div - DIV_W'(1));
    assign half       = div >> 1;

    // The edge that enters RUN only releases the channel (counter stays 0,
    // tick stays low); counting starts on the following edge. This places the
    // first pulse exactly DIV edges after sys_rst falls, and a resync behaves
    // exactly like a fresh RUN entry.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
            en_q <= 1'b0;
        end else begin
            en_q <= en;
            if (!en) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (degenerate) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else if (!en_q || resync) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else begin
                cnt  <= wrap ? '0 : cnt + DIV_W'(1);
                tick <= (mode == MODE_SQUARE) ? (cnt < half) : wrap;
            end
        end
    end

endmodule : tick_div

// File: rtl/clk_tick_gen.sv
// -----------------------------------------------------------------------------
// clk_tick_gen
//   Clock/reset sequencer placed after the PLL. Qualifies the PLL lock,
//   sequences the synchronous system reset, then runs NUM_CH independent
//   clock-enable channels. A lock drop while running re-enters the reset
//   sequence and sets a sticky lost_lock flag.
//
//   Parameters:
//     NUM_CH    number of enable channels
//     DIV_W     width of each divisor
//     DIVS      packed divisors, channel 0 in the LSBs
//     SQUARE    per-channel mode bit: 0 = pulse, 1 = square
//     LOCK_CYC  cycles synchronised lock must stay high (>= 1)
//     RST_HOLD  cycles sys_rst is held after lock is qualified (>= 1)
//
//   Ports:
//     clk        in   system clock (PLL output)
//     rst        in   asynchronous active-high reset
//     clk_ok     in   PLL lock, asynchronous to clk
//     resync     in   synchronous request to realign all channel counters
//     sys_rst    out  registered synchronous system reset, active-high
//     run        out  registered, high while in RUN
//     tick       out  per-channel enable / square outputs
//     lost_lock  out  sticky: lock dropped while in RUN, cleared only by rst
//
//   Latency: sys_rst falls on the (3 + LOCK_CYC + RST_HOLD)-th edge after
//   clk_ok rises and rises again on the 3rd edge after clk_ok falls
//   (2 synchroniser edges + 1 sequencer edge).
// -----------------------------------------------------------------------------
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int                       NUM_CH   = 4,
    parameter int                       DIV_W    = 16,
    parameter logic [NUM_CH*DIV_W-1:0]  DIVS     = {16'd2, 16'd3800, 16'd38000, 16'd38},
    parameter logic [NUM_CH-1:0]        SQUARE   = 4'b0000,
    parameter int                       LOCK_CYC = 1024,
    parameter int                       RST_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_ok,
    input  logic              resync,
    output logic              sys_rst,
    output logic              run,
    output logic [NUM_CH-1:0] tick,
    output logic              lost_lock
);

    // Shared sequencer counter, wide enough for the longer of the two phases.
    localparam int CNT_MAX = (LOCK_CYC > RST_HOLD) ? LOCK_CYC : RST_HOLD;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    // -------------------------------------------------------------------------
    // Lock synchroniser. clk_ok is asynchronous; nothing else looks at it.
    // -------------------------------------------------------------------------
    logic clk_ok_meta;
    logic clk_ok_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ok_meta <= 1'b0;
            clk_ok_s    <= 1'b0;
        end else begin
            clk_ok_meta <= clk_ok;
            clk_ok_s    <= clk_ok_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (clk_ok_s) begin
                    next_state = STABLE;
                    cnt_next   = '0;
                end
            end
            STABLE: begin
                if (!clk_ok_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == LOCK_LAST) begin
                    next_state = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!clk_ok_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    next_state = RUN;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!clk_ok_s) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from next_state so they change on the same edge
    // as the state itself, with no extra cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            sys_rst   <= 1'b1;
            run       <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            sys_rst <= (next_state != RUN);
            run     <= (next_state == RUN);
            // Only a drop seen while already running counts as lost lock;
            // drops during qualification simply restart the sequence.
            if (state == RUN && !clk_ok_s) begin
                lost_lock <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Channels. Enabling from next_state clears every counter and tick on the
    // very edge sys_rst asserts, so a lock loss never leaves a partial pulse.
    // -------------------------------------------------------------------------
    logic ch_en;
    logic ch_resync;

    assign ch_en     = (next_state == RUN);
    assign ch_resync = resync && (state == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_div #(
            .DIV_W (DIV_W)
        ) u_tick_div (
            .clk    (clk),
            .rst    (rst),
            .en     (ch_en),
            .resync (ch_resync),
            .div    (DIVS[i*DIV_W +: DIV_W]),
            .mode   (SQUARE[i]),
            .tick   (tick[i])
        );
    end

endmodule : clk_tick_gen

// File: tb/tb_clk_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_tick_gen
//   Directed bench for clk_tick_gen with short qualification times
//   (LOCK_CYC=4, RST_HOLD=2, so sys_rst falls on the 9th edge after clk_ok
//   rises). Channel set:
//     ch0 DIV=38 pulse, ch1 DIV=5 square, ch2 DIV=1 (constant 1),
//     ch3 DIV=2 square.
//   With k = edges after the RUN-entry edge, the tick after edge k is:
//     pulse : k % DIV == 0 (k >= 1)
//     square: (k-1) % DIV < DIV/2 (k >= 1)
//   and all-zero except ch2 on the RUN-entry edge itself (k = 0).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clk_tick_gen;

    logic       clk;
    logic       rst;
    logic       clk_ok;
    logic       resync;
    logic       sys_rst;
    logic       run;
    logic [3:0] tick;
    logic       lost_lock;

    int vectors     = 0;
    int miscompares = 0;

    clk_tick_gen #(
        .NUM_CH   (4),
        .DIV_W    (16),
        .DIVS     ({16'd2, 16'd1, 16'd5, 16'd38}),
        .SQUARE   (4'b1010),
        .LOCK_CYC (4),
        .RST_HOLD (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_ok    (clk_ok),
        .resync    (resync),
        .sys_rst   (sys_rst),
        .run       (run),
        .tick      (tick),
        .lost_lock (lost_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        clk_ok = 1'b0;
        resync = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_sys_rst",   sys_rst,   1);
        check("rst_run",       run,       0);
        check("rst_tick",      tick,      4'b0000);
        check("rst_lost_lock", lost_lock, 0);

        step(2);
        rst = 1'b0;
        step(3);
        check("nolock_sys_rst", sys_rst, 1);
        check("nolock_run",     run,     0);

        // ---- Bring-up: sys_rst falls on edge 9 after clk_ok rises ----------
        clk_ok = 1'b1;
        step(8);
        check("e8_sys_rst", sys_rst, 1);
        check("e8_run",     run,     0);
        check("e8_tick",    tick,    4'b0000);
        step(1);
        check("e9_sys_rst", sys_rst, 0);
        check("e9_run",     run,     1);
        check("k0_tick",    tick,    4'b0100);

        // ---- Running channels ---------------------------------------------
        step(1); check("k1_tick", tick, 4'b1110);
        step(1); check("k2_tick", tick, 4'b0110);
        step(1); check("k3_tick", tick, 4'b1100);
        step(1); check("k4_tick", tick, 4'b0100);
        step(1); check("k5_tick", tick, 4'b1100);
        step(1); check("k6_tick", tick, 4'b0110);
        step(31); check("k37_tick", tick, 4'b1110);
        step(1);  check("k38_tick", tick, 4'b0101);  // first ch0 pulse, edge 47
        step(1);  check("k39_tick", tick, 4'b1100);  // one cycle wide
        step(36); check("k75_tick0", tick[0], 0);
        step(1);  check("k76_tick0", tick[0], 1);    // second pulse, 38 later

        // ---- resync on the exact wrap edge of ch0 (k = 114) ----------------
        step(37); check("k113_tick0", tick[0], 0);
        resync = 1'b1;
        step(1);
        resync = 1'b0;
        check("resync_tick", tick, 4'b0100);         // wrap suppressed
        step(1);  check("r1_tick",  tick, 4'b1110);  // channels realigned
        step(36); check("r37_tick", tick, 4'b1110);
        step(1);  check("r38_tick", tick, 4'b0101);  // 38 after resync edge

        // ---- Lock loss in RUN ---------------------------------------------
        clk_ok = 1'b0;
        step(2);
        check("drop2_sys_rst",   sys_rst,   0);
        check("drop2_lost_lock", lost_lock, 0);
        check("drop2_tick",      tick,      4'b0100);
        step(1);
        check("drop3_sys_rst",   sys_rst,   1);
        check("drop3_run",       run,       0);
        check("drop3_tick",      tick,      4'b0000);
        check("drop3_lost_lock", lost_lock, 1);
        step(5);
        check("held_lost_lock",  lost_lock, 1);
        check("held_sys_rst",    sys_rst,   1);

        // ---- Relock with a 2-cycle glitch seen while STABLE cnt=2 ----------
        clk_ok = 1'b1;
        step(3);
        clk_ok = 1'b0;
        step(2);
        clk_ok = 1'b1;
        step(4);
        check("glitch_e9_sys_rst",  sys_rst, 1);     // no early release
        step(4);
        check("glitch_e13_sys_rst", sys_rst, 1);
        check("glitch_e13_run",     run,     0);
        step(1);
        check("glitch_e14_sys_rst", sys_rst, 0);     // 9 edges after recovery
        check("glitch_e14_run",     run,     1);
        check("glitch_lost_lock",   lost_lock, 1);
        check("relock_k0_tick",     tick,    4'b0100);
        step(1);
        check("relock_k1_tick",     tick,    4'b1110);

        // ---- Asynchronous reset between edges ------------------------------
        step(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sys_rst",   sys_rst,   1);
        check("arst_run",       run,       0);
        check("arst_tick",      tick,      4'b0000);
        check("arst_lost_lock", lost_lock, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clk_tick_gen
